// File: rtl/pattern_sweep.sv
// pattern_sweep: applies every N-bit stimulus pattern in binary or Gray order and records the response truth table
module pattern_sweep #(
   parameter int N    = 3,
   parameter int HOLD = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mode,
   input  logic              abort,
   input  logic              dut_out,
   output logic [N-1:0]      pattern,
   output logic              valid,
   output logic              busy,
   output logic              done,
   output logic [2**N-1:0]   truth_table,
   output logic [N:0]        ones_count
);
   localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;
   localparam logic [N:0]    LAST = (N+1)'(2**N - 1);
   localparam logic [HW-1:0] HMAX = HW'(HOLD - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state_q, state_d;
   logic [N:0]        idx_q, idx_d, idx_nx, gray_nx;
   logic [HW-1:0]     hc_q, hc_d;
   logic              mode_q, mode_d;
   logic [N-1:0]      pattern_q, pattern_d;
   logic [2**N-1:0]   tt_q, tt_d;
   logic [N:0]        ones_q, ones_d;

   // Next-state logic: accept a sweep, step patterns every HOLD cycles, capture responses
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      hc_d      = hc_q;
      mode_d    = mode_q;
      pattern_d = pattern_q;
      tt_d      = tt_q;
      ones_d    = ones_q;
      idx_nx    = idx_q + (N+1)'(1);
      gray_nx   = idx_nx ^ (idx_nx >> 1);
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d   = RUN;
               idx_d     = '0;
               hc_d      = '0;
               mode_d    = mode;
               pattern_d = '0;
               tt_d      = '0;
               ones_d    = '0;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
            end else if (hc_q == HMAX) begin
               tt_d[pattern_q] = dut_out;
               ones_d          = ones_q + (N+1)'(dut_out);
               hc_d            = '0;
               idx_d           = idx_nx;
               // The last pattern stays applied after the final sample
               if (idx_q == LAST) state_d = DONE;
               else pattern_d = mode_q ? gray_nx[N-1:0] : idx_nx[N-1:0];
            end else begin
               hc_d = hc_q + HW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         hc_q      <= '0;
         mode_q    <= 1'b0;
         pattern_q <= '0;
         tt_q      <= '0;
         ones_q    <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         hc_q      <= hc_d;
         mode_q    <= mode_d;
         pattern_q <= pattern_d;
         tt_q      <= tt_d;
         ones_q    <= ones_d;
      end
   end

   assign pattern     = pattern_q;
   assign valid       = state_q == RUN;
   assign busy        = state_q != IDLE;
   assign done        = state_q == DONE;
   assign truth_table = tt_q;
   assign ones_count  = ones_q;
endmodule
